ahb_lite_master_bridge: RTL and testbench
=========================================

// Module: ahb_lite_master_bridge
// PURPOSE
//  Converts the PRV32 core's native memory port (valid/ready, byte strobes) into single AHB-Lite
//  master transfers. Sits between core and AHB interconnect; drives the address/data phases seen
//  by the on-chip RAM and peripheral slaves. One outstanding transfer; no bursts, no pipelining.
// PARAMETERS
//  HPROT_DATA   4'b0011  hprot driven for data accesses (privileged, data)
//  HPROT_INSTR  4'b0010  hprot driven for instruction fetches (privileged, opcode)
// PORTS
//  hclk        in   1   bus clock
//  hreset      in   1   asynchronous reset, active-high
//  mem_valid   in   1   core request valid; held with all fields stable until mem_ready
//  mem_instr   in   1   request is instruction fetch
//  mem_addr    in   32  byte address
//  mem_wdata   in   32  write data, already lane-aligned by core
//  mem_wstrb   in   4   byte strobes; 4'b0000 = read
//  mem_ready   out  1   one-cycle completion pulse
//  mem_rdata   out  32  read data, valid while mem_ready=1, held until next completion
//  mem_err     out  1   qualifies mem_ready: bus ERROR or illegal strobe pattern
//  htrans      out  2   IDLE(00) / NONSEQ(10) only
//  haddr       out  32  transfer address
//  hwrite      out  1   1 = write
//  hsize       out  3   000 byte, 001 half, 010 word
//  hburst      out  3   constant 3'b000 (SINGLE)
//  hprot       out  4   HPROT_INSTR if mem_instr else HPROT_DATA
//  hwdata      out  32  write data, driven during data phase
//  hready      in   1   bus ready (from interconnect mux)
//  hresp       in   2   slave response; bit0=1 means ERROR
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; htrans=00, haddr=0, hwrite=0, hsize=010, hprot=HPROT_DATA,
//   hwdata=0, mem_ready=0, mem_rdata=0, mem_err=0, err latch=0. Reset mid-transfer abandons it.
//  All outputs registered. FSM states: IDLE, ADDR, DATA, DONE.
//  IDLE: if mem_valid: decode strobes.
//   legal -> load haddr/hsize/hwrite/hprot, htrans=NONSEQ, go ADDR.
//   illegal -> no bus transfer, go DONE with mem_err=1.
//  Strobe decode: 0000 read word, haddr[1:0]=00; 1111 word, 00; 0011 half, 00; 1100 half, 10;
//   0001/0010/0100/1000 byte, offset 00/01/10/11; haddr[31:2]=mem_addr[31:2].
//   All other patterns illegal.
//  ADDR: htrans stays NONSEQ until sampled with hready=1; then htrans=IDLE,
//   hwdata=mem_wdata (writes), go DATA.
//  DATA: wait for hready=1. Any cycle with hresp[0]=1 sets err latch (covers 2-cycle ERROR).
//   On hready=1: mem_rdata<=hrdata for reads (unchanged for writes),
//   mem_err<=latch|hresp[0], go DONE.
//  DONE: mem_ready=1 for exactly this cycle; clear err latch; go IDLE.
//   mem_valid is ignored in DONE (core drops or re-issues after seeing ready).
//  Latency, zero wait states: mem_valid seen cycle 0 -> NONSEQ cycle 1 -> data phase cycle 2
//   -> mem_ready cycle 3. Each slave wait state adds one cycle.
//  htrans never NONSEQ in DATA/DONE: no back-to-back overlap.
//  mem_ready/mem_err low in all states except DONE.
// TESTING
//  1 Read 0x0000_0010, wstrb=0, hready=1 always, slave returns 0xDEADBEEF -> NONSEQ cycle 1,
//    haddr=0x10, hsize=010, mem_ready cycle 3, mem_rdata=0xDEADBEEF, mem_err=0.
//  2 Write strobes 0100 addr 0x20, wdata 0x00AB0000 -> haddr=0x22, hsize=000, hwrite=1,
//    hwdata=0x00AB0000 in data phase; half 1100 -> haddr=0x22, hsize=001.
//  3 Two wait states in data phase (hready=0,0,1) -> mem_ready delayed to cycle 5; read with
//    hready=0 in address phase -> NONSEQ held stable, haddr unchanged.
//  4 Two-cycle ERROR (hready=0/hresp=01, then hready=1/hresp=01) -> mem_ready=1 with mem_err=1;
//    following good transfer reports mem_err=0.
//  5 Illegal strobe 0101 -> htrans stays 00 throughout, mem_ready=1, mem_err=1 on cycle 1.
//  6 Assert hreset during DATA -> outputs at reset values same cycle. After release,
//    new request completes normally.

Source files
------------

// File: rtl/ahb_lite_master_bridge.sv
// Bridges the PRV32 valid/ready memory port onto single, non-pipelined AHB-Lite master transfers.
// One transfer in flight; every bus-facing and core-facing output comes straight from a flop.
module ahb_lite_master_bridge #(
  parameter logic [3:0] HPROT_DATA  = 4'b0011,
  parameter logic [3:0] HPROT_INSTR = 4'b0010
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [3:0]  hprot_q, hprot_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_err_q, mem_err_d;
  logic        err_q, err_d;

  logic        legal_s;
  logic [2:0]  size_s;
  logic [1:0]  off_s;

  // Strobe pattern -> transfer size and low address bits; anything not naturally aligned is illegal.
  always_comb begin
    legal_s = 1'b1;
    size_s  = 3'b010;
    off_s   = 2'b00;
    case (mem_wstrb)
      4'b0000, 4'b1111: begin size_s = 3'b010; off_s = 2'b00; end
      4'b0011:          begin size_s = 3'b001; off_s = 2'b00; end
      4'b1100:          begin size_s = 3'b001; off_s = 2'b10; end
      4'b0001:          begin size_s = 3'b000; off_s = 2'b00; end
      4'b0010:          begin size_s = 3'b000; off_s = 2'b01; end
      4'b0100:          begin size_s = 3'b000; off_s = 2'b10; end
      4'b1000:          begin size_s = 3'b000; off_s = 2'b11; end
      default:          begin legal_s = 1'b0; size_s = 3'b010; off_s = 2'b00; end
    endcase
  end

  // Transfer sequencing; mem_ready/mem_err are loaded on entry to DONE so they are high only there.
  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    hwdata_d    = hwdata_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_err_d   = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && legal_s) begin
          haddr_d  = {mem_addr[31:2], off_s};
          hsize_d  = size_s;
          hwrite_d = (mem_wstrb != 4'b0000);
          hprot_d  = mem_instr ? HPROT_INSTR : HPROT_DATA;
          htrans_d = TRANS_NONSEQ;
          state_d  = ST_ADDR;
        end else if (mem_valid) begin
          mem_ready_d = 1'b1;
          mem_err_d   = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          htrans_d = TRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = mem_wdata;
          end else begin
            hwdata_d = hwdata_q;
          end
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (hready) begin
          if (!hwrite_q) begin
            mem_rdata_d = hrdata;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
          mem_ready_d = 1'b1;
          mem_err_d   = err_q | hresp[0];
          state_d     = ST_DONE;
        end else begin
          // First cycle of a two-cycle ERROR arrives with hready low.
          err_d = err_q | hresp[0];
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      htrans_q    <= TRANS_IDLE;
      haddr_q     <= 32'h0000_0000;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b010;
      hprot_q     <= HPROT_DATA;
      hwdata_q    <= 32'h0000_0000;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      mem_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      hwdata_q    <= hwdata_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      mem_err_q   <= mem_err_d;
      err_q       <= err_d;
    end
  end

  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = 3'b000;
  assign hprot     = hprot_q;
  assign hwdata    = hwdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Scoreboard bench: driver queues expected bus transfers and core responses; a slave model and
// a response monitor consume them independently.
module tb_ahb_lite_master_bridge;

  logic        hclk, hreset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_err;
  logic [31:0] mem_rdata;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  ahb_lite_master_bridge dut (
    .hclk(hclk), .hreset(hreset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [3:0]  hprot;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
  } rsp_t;

  plan_t       plan_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] model_rdata;
  int          cyc;
  int          n_cmp;
  int          n_bad;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference view of a strobe pattern: legal if read, single byte, aligned half or full word.
  task automatic classify(input logic [3:0] s, output bit legal, output logic [2:0] sz,
                          output logic [1:0] off);
    int n;
    n = $countones(s);
    legal = (n <= 1) || (s == 4'b0011) || (s == 4'b1100) || (s == 4'b1111);
    sz = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
    off = 2'd0;
    for (int i = 3; i >= 0; i--) if (s[i]) off = 2'(i);
  endtask

  task automatic check_reset_values();
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwrite", 32'(hwrite), 32'h0);
    check("rst_hsize", 32'(hsize), 32'h2);
    check("rst_hprot", 32'(hprot), 32'h3);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_mem_ready", 32'(mem_ready), 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'h0);
  endtask

  task automatic queue_plan(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int aw, input int dw, input logic berr,
                            input logic [31:0] rd, output bit legal);
    plan_t p;
    logic [2:0] sz;
    logic [1:0] off;
    classify(strb, legal, sz, off);
    if (legal) begin
      p.haddr  = {addr[31:2], off};
      p.hsize  = sz;
      p.hwrite = (strb != 4'b0000);
      p.hprot  = instr ? 4'b0010 : 4'b0011;
      p.wdata  = wdata;
      p.aw     = aw;
      p.dw     = dw;
      p.err    = berr;
      p.rdata  = rd;
      plan_q.push_back(p);
    end
  endtask

  task automatic issue(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int aw, input int dw, input logic berr,
                       input logic [31:0] rd);
    bit legal;
    rsp_t r;
    int t;
    @(negedge hclk);
    queue_plan(instr, addr, wdata, strb, aw, dw, berr, rd, legal);
    if (legal) begin
      if (strb == 4'b0000) model_rdata = rd;
      r.err = berr;
      r.done_cyc = cyc + 3 + aw + dw;
    end else begin
      r.err = 1'b1;
      r.done_cyc = cyc + 1;
    end
    r.rdata = model_rdata;
    rsp_q.push_back(r);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    t = 0;
    do begin
      @(negedge hclk);
      t++;
    end while (!mem_ready && t < 60);
    if (!mem_ready) check("ready_timeout", 32'(t), 32'(r.done_cyc));
    mem_valid = 1'b0;
  endtask

  // Slave: follows the queued plan for each NONSEQ, checking the address and data phases it sees.
  initial begin
    plan_t p;
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    forever begin
      @(negedge hclk);
      if (!hreset && htrans == 2'b10) begin
        if (plan_q.size() == 0) begin
          check("unexpected_nonseq", 32'(htrans), 32'h0);
        end else begin
          p = plan_q.pop_front();
          check("haddr", haddr, p.haddr);
          check("hsize", 32'(hsize), 32'(p.hsize));
          check("hwrite", 32'(hwrite), 32'(p.hwrite));
          check("hprot", 32'(hprot), 32'(p.hprot));
          check("hburst", 32'(hburst), 32'h0);
          for (int i = 0; i < p.aw; i++) begin
            hready = 1'b0;
            @(negedge hclk);
            check("nonseq_held", 32'(htrans), 32'h2);
            check("haddr_held", haddr, p.haddr);
          end
          hready = 1'b1;
          @(negedge hclk);
          check("htrans_data", 32'(htrans), 32'h0);
          if (p.hwrite) check("hwdata", hwdata, p.wdata);
          for (int i = 0; i < p.dw; i++) begin
            hready = 1'b0;
            hresp  = (p.err && i == p.dw - 1) ? 2'b01 : 2'b00;
            hrdata = $urandom;
            @(negedge hclk);
          end
          hready = 1'b1;
          hresp  = p.err ? 2'b01 : 2'b00;
          hrdata = p.rdata;
          @(negedge hclk);
          hresp = 2'b00;
        end
      end
    end
  end

  // Monitor: every completion pulse is matched against the oldest expected response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge hclk);
      if (mem_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_ready", 32'(mem_ready), 32'h0);
        end else begin
          r = rsp_q.pop_front();
          check("mem_err", 32'(mem_err), 32'(r.err));
          check("mem_rdata", mem_rdata, r.rdata);
          check("ready_cycle", 32'(cyc), 32'(r.done_cyc));
        end
      end else if (mem_err) begin
        check("err_without_ready", 32'(mem_err), 32'h0);
      end
    end
  end

  initial begin
    logic [3:0] legal_strb [8];
    logic [3:0] s;
    bit legal;
    int t;
    legal_strb = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    n_cmp = 0;
    n_bad = 0;
    model_rdata = 32'h0;
    hreset = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (2) @(negedge hclk);
    check_reset_values();
    hreset = 1'b0;

    issue(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, 0, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_0020, 32'h00AB_0000, 4'b0100, 0, 0, 1'b0, 32'h0);
    issue(1'b0, 32'h0000_0020, 32'hABCD_0000, 4'b1100, 0, 0, 1'b0, 32'h0);
    issue(1'b0, 32'h0000_0030, 32'h0, 4'b0000, 0, 2, 1'b0, 32'h1234_5678);
    issue(1'b1, 32'h0000_0040, 32'h0, 4'b0000, 2, 0, 1'b0, 32'h0BAD_F00D);
    issue(1'b0, 32'h0000_0050, 32'h0, 4'b0000, 0, 1, 1'b1, 32'h55AA_55AA);
    issue(1'b0, 32'h0000_0054, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h1111_2222);
    issue(1'b0, 32'h0000_0060, 32'h0000_0001, 4'b0101, 0, 0, 1'b0, 32'h0);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge hclk);
      if ($urandom_range(0, 3) == 0) s = 4'($urandom);
      else s = legal_strb[$urandom_range(0, 7)];
      issue(1'($urandom), $urandom, $urandom, s, $urandom_range(0, 2), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0), $urandom);
    end

    // Reset in the middle of a data phase abandons the transfer.
    @(negedge hclk);
    queue_plan(1'b0, 32'h0000_0044, 32'hCAFE_F00D, 4'b1111, 0, 6, 1'b0, 32'h0, legal);
    mem_valid = 1'b1;
    mem_instr = 1'b0;
    mem_addr  = 32'h0000_0044;
    mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'b1111;
    repeat (2) @(negedge hclk);
    hreset = 1'b1;
    #1;
    check_reset_values();
    mem_valid = 1'b0;
    model_rdata = 32'h0;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    repeat (8) @(negedge hclk);
    issue(1'b0, 32'h0000_0070, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h7777_8888);
    issue(1'b0, 32'h0000_0074, 32'h0000_BB00, 4'b0010, 1, 1, 1'b0, 32'h0);

    t = 0;
    while (rsp_q.size() != 0 && t < 20) begin
      @(negedge hclk);
      t++;
    end
    repeat (2) @(negedge hclk);
    check("pending_rsp", 32'(rsp_q.size()), 32'h0);
    check("pending_plan", 32'(plan_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
